// File: rtl/mdom_wfm_capture.sv
// mdom_wfm_capture: circular pre-trigger history, fixed post window, header+sample readout over valid/ready.
// Rev 1.0
`default_nettype none

module mdom_wfm_capture #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       adc_stream_in,
  input  logic [7:0]        discr_stream_in,
  input  logic              trig,
  input  logic [1:0]        trig_src,
  input  logic              arm,
  input  logic [7:0]        pre_conf,
  input  logic [ADDR_W-2:0] post_conf,
  input  logic [47:0]       ltc,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HDR0  = 3'd4,
    S_HDR1  = 3'd5,
    S_HDR2  = 3'd6,
    S_DATA  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     post_cnt_q, post_cnt_d;
  logic [7:0]        fill_q, fill_d;
  logic [1:0]        src_q, src_d;
  logic [47:0]       ltc_q, ltc_d;
  logic [15:0]       drop_q, drop_d;
  logic              trig_d_q;
  logic              wr_en;
  logic              hs;
  logic [19:0]       mem_q [DEPTH];
  logic [19:0]       mem_rd_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    post_cnt_d = post_cnt_q;
    fill_d     = fill_q;
    src_d      = src_q;
    ltc_d      = ltc_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    out_valid  = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                 (state_q == S_HDR2) || (state_q == S_DATA);
    busy       = out_valid || (state_q == S_POST);
    out_last   = (state_q == S_DATA) && (rem_q == ADDR_W'(1));
    hs         = out_valid && out_ready;
    out_data   = 32'h0;

    case (state_q)
      S_IDLE: begin
        wr_en = 1'b1;
        if (arm) state_d = S_FILL;
      end
      S_FILL: begin
        wr_en = 1'b1;
        if (fill_q != 8'hFF) fill_d = fill_q + 8'd1;
        if (fill_q >= pre_conf) state_d = S_ARMED;
      end
      S_ARMED: begin
        wr_en = 1'b1;
        if (trig) begin
          src_d      = trig_src;
          ltc_d      = ltc;
          // rd_ptr doubles as the event start; wr_ptr still points at the trigger sample
          rd_ptr_d   = wr_ptr_q - ADDR_W'(pre_conf);
          len_d      = ADDR_W'(pre_conf) + ADDR_W'(1) + ADDR_W'(post_conf);
          rem_d      = ADDR_W'(pre_conf) + ADDR_W'(1) + ADDR_W'(post_conf);
          post_cnt_d = post_conf;
          state_d    = (post_conf == '0) ? S_HDR0 : S_POST;
        end else if (!arm) begin
          state_d = S_IDLE;
        end
      end
      S_POST: begin
        wr_en      = 1'b1;
        post_cnt_d = post_cnt_q - PW'(1);
        if (post_cnt_q == PW'(1)) state_d = S_HDR0;
      end
      S_HDR0: begin
        out_data = {8'hA5, 6'b0, src_q, 16'(len_q)};
        if (hs) state_d = S_HDR1;
      end
      S_HDR1: begin
        out_data = ltc_q[47:16];
        if (hs) state_d = S_HDR2;
      end
      S_HDR2: begin
        out_data = {ltc_q[15:0], 16'h0000};
        if (hs) state_d = S_DATA;
      end
      S_DATA: begin
        out_data = {12'h000, mem_rd_q};
        if (hs) begin
          if (rem_q == ADDR_W'(1)) begin
            state_d = arm ? S_FILL : S_IDLE;
            fill_d  = 8'd0;
          end else begin
            rem_d    = rem_q - ADDR_W'(1);
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (trig && !trig_d_q && arm && (state_q != S_ARMED) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      post_cnt_q <= '0;
      fill_q     <= 8'd0;
      src_q      <= 2'd0;
      ltc_q      <= 48'd0;
      drop_q     <= 16'd0;
      trig_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      post_cnt_q <= post_cnt_d;
      fill_q     <= fill_d;
      src_q      <= src_d;
      ltc_q      <= ltc_d;
      drop_q     <= drop_d;
      trig_d_q   <= trig;
    end
  end

  // Reading at the next pointer keeps the registered read data aligned with
  // the presented word, so stalls re-read the same address and HDR2->DATA has no bubble.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {discr_stream_in, adc_stream_in};
    mem_rd_q <= mem_q[rd_ptr_d];
  end

endmodule

`default_nettype wire

// File: tb/tb_mdom_wfm_capture.sv
// tb_mdom_wfm_capture: randomized stimulus against an event-level reference model.
// Rev 1.0
`default_nettype none

module tb_mdom_wfm_capture;

  localparam int LIMIT = 20000;

  logic        clk, rst;
  logic [11:0] adc_stream_in;
  logic [7:0]  discr_stream_in;
  logic        trig, arm, out_ready;
  logic [1:0]  trig_src;
  logic [7:0]  pre_conf;
  logic [8:0]  post_conf;
  logic [47:0] ltc;
  logic [31:0] out_data;
  logic        out_valid, out_last, busy;
  logic [15:0] drop_cnt;

  mdom_wfm_capture #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .adc_stream_in(adc_stream_in), .discr_stream_in(discr_stream_in),
    .trig(trig), .trig_src(trig_src), .arm(arm), .pre_conf(pre_conf), .post_conf(post_conf),
    .ltc(ltc), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one entry per cycle at the falling edge
  int          cyc = 0;
  logic [19:0] hist [4096];
  logic [32:0] exp_q [$];
  bit          m_busy = 0;
  int          armed_at = 0;
  int          post_left = 0;
  int          hdr_dl = 0;
  int          drop_exp = 0;
  bit          trig_prev = 0;
  bit          was_rst = 0, after_last = 0, chk_busy = 0, prev_stall = 0;
  logic [31:0] prev_data;
  bit          prev_last;

  always @(negedge clk) begin : model
    int len;
    bit in_armed;
    if (rst) begin
      exp_q.delete();
      m_busy = 0; post_left = 0; drop_exp = 0; trig_prev = 0;
      after_last = 0; chk_busy = 0; prev_stall = 0; was_rst = 1;
      armed_at = cyc + 3 + int'(pre_conf);
    end else begin
      if (was_rst) begin
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_busy", busy, 0);
        was_rst = 0;
      end
      check_eq("drop_cnt", drop_cnt, 48'(drop_exp));
      if (after_last) begin
        check_eq("valid_after_last", out_valid, 0);
        check_eq("busy_after_last", busy, 0);
        after_last = 0;
      end
      if (chk_busy) begin
        check_eq("busy_after_accept", busy, 1);
        chk_busy = 0;
      end
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, 48'(prev_data));
        check_eq("stall_last", out_last, prev_last);
      end
      if (m_busy && cyc == hdr_dl) check_eq("hdr_latency", out_valid, 1);

      hist[cyc % 4096] = {discr_stream_in, adc_stream_in};
      if (post_left > 0) begin
        exp_q.push_back({post_left == 1, 12'h000, discr_stream_in, adc_stream_in});
        post_left--;
      end

      in_armed = !m_busy && (cyc >= armed_at);
      if (trig && !trig_prev && arm && !in_armed && drop_exp < 65535) drop_exp++;
      if (trig && in_armed) begin
        len = int'(pre_conf) + 1 + int'(post_conf);
        exp_q.push_back({1'b0, 8'hA5, 6'b0, trig_src, 16'(len)});
        exp_q.push_back({1'b0, ltc[47:16]});
        exp_q.push_back({1'b0, ltc[15:0], 16'h0000});
        for (int i = 0; i <= int'(pre_conf); i++)
          exp_q.push_back({(i == int'(pre_conf)) && (post_conf == 0), 12'h000,
                           hist[(cyc - int'(pre_conf) + i) % 4096]});
        post_left = int'(post_conf);
        m_busy    = 1;
        chk_busy  = 1;
        hdr_dl    = cyc + int'(post_conf) + 3;
      end
      trig_prev = trig;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", out_data, 48'hDEAD_0000_0000);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check_eq("data", out_data, 48'(e[31:0]));
          check_eq("last", out_last, e[32]);
          if (e[32]) begin
            m_busy     = 0;
            after_last = 1;
            armed_at   = cyc + 2 + int'(pre_conf);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    cyc++;
  end

  // Stimulus
  int rdy_mode = 0;

  task automatic tick();
    adc_stream_in   = 12'($urandom);
    discr_stream_in = 8'($urandom);
    ltc             = ltc + 48'd1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] src);
    trig     = 1'b1;
    trig_src = src;
    tick();
    trig     = 1'b0;
    trig_src = 2'($urandom);
  endtask

  task automatic wait_armed(input int margin);
    int n = 0;
    while ((m_busy || cyc < armed_at + margin) && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) check_eq("wait_armed_timeout", 48'(n), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((m_busy || exp_q.size() != 0) && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) check_eq("wait_done_timeout", 48'(n), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int rst_k, target, n;
    rst = 1'b1; arm = 1'b1; trig = 1'b0; trig_src = 2'd0;
    pre_conf = 8'd4; post_conf = 9'd3;
    ltc = {16'($urandom), 32'($urandom)};
    adc_stream_in = '0; discr_stream_in = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // pre 4 / post 3, then pre 0 / post 0
    wait_armed(2); pulse(2'd2); pre_conf = 8'd0; post_conf = 9'd0; wait_done();
    wait_armed(2); pulse(2'd1); pre_conf = 8'd20; post_conf = 9'd10; wait_done();

    // level trigger held through the event
    wait_armed(2);
    trig = 1'b1; trig_src = 2'd3; tick();
    pre_conf = 8'd6; post_conf = 9'd5;
    repeat (39) tick();
    trig = 1'b0;
    wait_done();
    check_eq("held_trig_drops", drop_cnt, 0);

    // three pulses while the sink stalls
    rdy_mode = 2;
    wait_armed(2); pulse(2'd0); pre_conf = 8'd30; post_conf = 9'd15;
    repeat (3) begin repeat (4) tick(); pulse(2'($urandom)); end
    check_eq("stalled_drops", drop_cnt, 3);
    rdy_mode = 0;
    wait_done();

    // backpressure across two events, with a too-early trigger between them
    rdy_mode = 1;
    wait_armed(2); pulse(2'($urandom)); wait_done();
    repeat (3) tick();
    pulse(2'($urandom));
    wait_armed(2); pulse(2'($urandom)); wait_done();

    // reset during readout, then a 255-sample pre window that straddles address 0
    wait_armed(2); pulse(2'($urandom));
    pre_conf = 8'd255; post_conf = 9'd20;
    n = 0;
    while (exp_q.size() > 20 && n < LIMIT) begin tick(); n++; end
    rst = 1'b1; tick(); rst_k = cyc; tick(); rst = 1'b0;
    target = rst_k + 1 + 1024 + 100;
    while (cyc < target && n < LIMIT) begin tick(); n++; end
    pulse(2'($urandom)); pre_conf = 8'($urandom_range(0, 40)); post_conf = 9'($urandom_range(0, 40));
    wait_done();

    // random configurations
    for (int i = 0; i < 4; i++) begin
      wait_armed(2 + int'($urandom_range(0, 5)));
      pulse(2'($urandom));
      pre_conf  = 8'($urandom_range(0, 60));
      post_conf = 9'($urandom_range(0, 60));
      wait_done();
    end
    repeat (4) tick();
    check_eq("queue_empty", 48'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
